// File: rtl/alu_issue_unit.sv
// Issue unit that sequences one request at a time through an external ALU:
// drive operands for two cycles, capture result and flags, hold the response until taken.
module alu_issue_unit #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [2:0]        reqOp,
    input  logic [DATA_W-1:0] reqA,
    input  logic [DATA_W-1:0] reqB,
    output logic              aluActiveIn,
    output logic              aluOpB1,
    output logic              aluOpB2,
    output logic              aluOpB3,
    output logic [DATA_W-1:0] dataIn1,
    output logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataOut,
    input  logic              zero,
    input  logic              lt,
    input  logic              gt,
    input  logic              cIn,
    input  logic              overflow,
    input  logic              cOut,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspData,
    output logic [5:0]        rspFlags,
    output logic              rspErr,
    output logic [7:0]        opCount
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_p0;
    logic [DATA_W-1:0] a_p0, b_p0;
    logic              accept, drive, rsp_take;

    function automatic logic op_legal(input logic [2:0] op);
        return op < 3'd6;
    endfunction

    assign accept   = (state == IDLE) && reqValid;
    assign drive    = (state == DRIVE) || (state == CAPTURE);
    assign rsp_take = (state == HOLD) && rspReady;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (reqValid) state_nxt = op_legal(reqOp) ? DRIVE : HOLD;
            DRIVE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (rspReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request operands held for the whole DRIVE/CAPTURE window
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_p0 <= reqOp;
            a_p0  <= reqA;
            b_p0  <= reqB;
        end
    end

    // Response stage: illegal opcodes bypass the ALU and report an error with zeroed payload
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rspData  <= '0;
            rspFlags <= '0;
            rspErr   <= 1'b0;
            opCount  <= 8'd0;
        end else begin
            if (accept && !op_legal(reqOp)) begin
                rspData  <= '0;
                rspFlags <= '0;
                rspErr   <= 1'b1;
            end else if (state == CAPTURE) begin
                rspData  <= dataOut;
                rspFlags <= {overflow, cOut, cIn, gt, lt, zero};
                rspErr   <= 1'b0;
            end
            if (rsp_take && !rspErr) opCount <= opCount + 8'd1;
        end
    end

    assign reqReady    = (state == IDLE);
    assign rspValid    = (state == HOLD);
    assign aluActiveIn = drive;
    assign aluOpB1     = drive & op_p0[2];
    assign aluOpB2     = drive & op_p0[1];
    assign aluOpB3     = drive & op_p0[0];
    assign dataIn1     = drive ? a_p0 : '0;
    assign dataIn2     = drive ? b_p0 : '0;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomized bench for alu_issue_unit: a behavioural ALU stub answers the DUT, and a
// transaction-level model predicts every response, the ALU drive window and opCount.
module tb_alu_issue_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [2:0]  reqOp = 3'd0;
    logic [15:0] reqA = 16'd0;
    logic [15:0] reqB = 16'd0;
    logic        aluActiveIn, aluOpB1, aluOpB2, aluOpB3;
    logic [15:0] dataIn1, dataIn2, dataOut;
    logic        zero, lt, gt, cIn, overflow, cOut;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [15:0] rspData;
    logic [5:0]  rspFlags;
    logic        rspErr;
    logic [7:0]  opCount;

    int vectors = 0;
    int miscompares = 0;
    int exp_count = 0;

    alu_issue_unit dut (
        .CLK(CLK), .RST_N(RST_N),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqA(reqA), .reqB(reqB),
        .aluActiveIn(aluActiveIn), .aluOpB1(aluOpB1), .aluOpB2(aluOpB2), .aluOpB3(aluOpB3),
        .dataIn1(dataIn1), .dataIn2(dataIn2), .dataOut(dataOut),
        .zero(zero), .lt(lt), .gt(gt), .cIn(cIn), .overflow(overflow), .cOut(cOut),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspFlags(rspFlags),
        .rspErr(rspErr), .opCount(opCount)
    );

    always #5 CLK = ~CLK;

    // Returns {overflow, cOut, cIn, gt, lt, zero, result}
    function automatic logic [21:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        logic [15:0] r;
        logic        ov, co;
        sum = 17'd0; r = 16'd0; ov = 1'b0; co = 1'b0;
        case (op)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, b}; r = sum[15:0]; co = sum[16];
                ov = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: begin
                sum = {1'b0, a} - {1'b0, b}; r = sum[15:0]; co = sum[16];
                ov = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd5: begin sum = {1'b0, a} + {1'b0, b}; r = sum[15:0]; co = sum[16]; end
            default: r = 16'd0;
        endcase
        return {ov, co, op[0] & a[0], $signed(a) > $signed(b), $signed(a) < $signed(b), r == 16'd0, r};
    endfunction

    always_comb begin
        {overflow, cOut, cIn, gt, lt, zero, dataOut} = alu_ref({aluOpB1, aluOpB2, aluOpB3}, dataIn1, dataIn2);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_ready", reqReady, 1);
        check_val("rst_active", aluActiveIn, 0);
        check_val("rst_opb", {aluOpB1, aluOpB2, aluOpB3}, 0);
        check_val("rst_din", {dataIn1, dataIn2}, 0);
        check_val("rst_valid", rspValid, 0);
        check_val("rst_data", rspData, 0);
        check_val("rst_flags", rspFlags, 0);
        check_val("rst_err", rspErr, 0);
        check_val("rst_count", opCount, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int stall);
        logic [21:0] exp;
        logic        legal;
        legal = (op < 3'd6);
        exp = legal ? alu_ref(op, a, b) : 22'd0;
        check_val("idle_ready", reqReady, 1);
        reqValid = 1'b1; reqOp = op; reqA = a; reqB = b; rspReady = 1'b0;
        @(negedge CLK);
        reqValid = 1'($urandom_range(0, 1)); reqOp = 3'($urandom); reqA = 16'($urandom); reqB = 16'($urandom);
        if (legal) begin
            repeat (2) begin
                check_val("drv_active", aluActiveIn, 1);
                check_val("drv_opb", {aluOpB1, aluOpB2, aluOpB3}, op);
                check_val("drv_in1", dataIn1, a);
                check_val("drv_in2", dataIn2, b);
                check_val("drv_valid", rspValid, 0);
                check_val("drv_ready", reqReady, 0);
                @(negedge CLK);
            end
        end
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) begin rspReady = 1'b1; reqValid = 1'b0; end
            check_val("hold_valid", rspValid, 1);
            check_val("hold_data", rspData, exp[15:0]);
            check_val("hold_flags", rspFlags, exp[21:16]);
            check_val("hold_err", rspErr, !legal);
            check_val("hold_ready", reqReady, 0);
            check_val("hold_active", aluActiveIn, 0);
            check_val("hold_opb", {aluOpB1, aluOpB2, aluOpB3}, 0);
            check_val("hold_din", {dataIn1, dataIn2}, 0);
            @(negedge CLK);
        end
        rspReady = 1'b0;
        if (legal) exp_count = (exp_count + 1) % 256;
        check_val("idle_valid", rspValid, 0);
        check_val("idle_count", opCount, exp_count);
    endtask

    initial begin
        logic [2:0]  op;
        logic [15:0] a, b;
        #12;
        check_reset_outputs();
        @(negedge CLK);
        RST_N = 1'b1;

        run_op(3'd0, 16'h0001, 16'h0002, 0);
        check_val("add_lt", rspFlags[1], 1);
        run_op(3'd4, 16'h0491, 16'h04B1, 1);
        run_op(3'd7, 16'h1234, 16'h5678, 0);
        run_op(3'd6, 16'hFFFF, 16'h0001, 2);
        run_op(3'd1, 16'h0005, 16'h0005, 3);

        // Reset pulse while the operation is in CAPTURE discards it
        check_val("pre_rst_count", opCount, exp_count);
        reqValid = 1'b1; reqOp = 3'd0; reqA = 16'h00AA; reqB = 16'h0055;
        @(negedge CLK);
        reqValid = 1'b0;
        @(negedge CLK);
        check_val("cap_active", aluActiveIn, 1);
        #2 RST_N = 1'b0;
        #1;
        exp_count = 0;
        check_reset_outputs();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_val("post_rst_valid", rspValid, 0);
        check_val("post_rst_count", opCount, 0);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 0);

        // Back-to-back legal traffic until opCount wraps through 0xFF
        for (int n = 0; n < 255; n++) begin
            op = 3'($urandom_range(0, 5));
            run_op(op, 16'($urandom), 16'($urandom), 0);
        end
        check_val("wrap_count", opCount, 8'h00);

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
